// File: rtl/alu_chain_pipe.sv
// alu_chain_pipe: STAGES-deep registered ALU chain with valid/ready flow control,
// accumulator feedback and runtime opcodes. Define ALU_CHAIN_SAT_EN for saturating ADD/SUB.

module alu_chain_stage #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] smp
);
  logic [WIDTH-1:0] alu;

`ifdef ALU_CHAIN_SAT_EN
  // carry/borrow lands in the extra top bit
  logic [WIDTH:0] sum, dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
`endif

  always_comb begin
    alu = a;
    case (op)
`ifdef ALU_CHAIN_SAT_EN
      3'b000: alu = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      3'b001: alu = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
`else
      3'b000: alu = a + b;
      3'b001: alu = a - b;
`endif
      3'b010: alu = a & b;
      3'b011: alu = a | b;
      3'b100: alu = a ^ b;
      3'b101: alu = a << b[2:0];
      3'b110: alu = a;
      3'b111: alu = b;
      default: alu = a;
    endcase
  end

  // sample rides alongside the result so the next stage sees the same B
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      smp <= '0;
    end else if (en) begin
      res <= alu;
      smp <= b;
    end
  end
endmodule

module alu_chain_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int OPW    = 3
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic                  validi,
  output logic                  ready_o,
  input  logic [WIDTH-1:0]      data_in,
  output logic                  valido,
  input  logic                  readyi,
  output logic [WIDTH-1:0]      data_out,
  output logic [WIDTH-1:0]      acc_out,
  input  logic                  acc_clr,
  input  logic                  cfg_we,
  input  logic [STAGES*OPW-1:0] op_cfg,
  output logic                  cfg_busy
);
  logic                         en, accept, cfg_load;
  logic [STAGES:1]              vld_q;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0] res_q, smp_q, a_in, b_in;
  logic [STAGES-1:0][OPW-1:0]   op_q;
  logic [WIDTH-1:0]             acc_q;
  logic                         unused_smp;

  // one global enable: the whole chain stalls only when the output is held
  assign en       = !valido || readyi;
  assign ready_o  = en;
  assign accept   = validi && en;
  assign vld_pipe = {vld_q, validi};
  assign valido   = vld_pipe[STAGES];
  assign cfg_busy = |vld_pipe[STAGES:1];
  assign cfg_load = cfg_we && !cfg_busy && !accept;
  assign data_out = res_q[STAGES-1];
  assign acc_out  = acc_q;

  always_comb begin
    a_in    = '0;
    b_in    = '0;
    a_in[0] = acc_q;
    b_in[0] = data_in;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = res_q[k-1];
      b_in[k] = smp_q[k-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      alu_chain_stage #(.WIDTH(WIDTH), .OPW(OPW)) u_stage (
        .clk (Clk),
        .rst (rst),
        .en  (en),
        .op  (op_q[g]),
        .a   (a_in[g]),
        .b   (b_in[g]),
        .res (res_q[g]),
        .smp (smp_q[g])
      );
    end
  endgenerate

  // the final stage's carried sample has no consumer
  assign unused_smp = ^smp_q[STAGES-1];

  always_ff @(posedge Clk) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      op_q    <= '0;
      op_q[0] <= OPW'(6);
    end else if (cfg_load) begin
      op_q <= op_cfg;
    end
  end

  // clear wins over the handshake update; stage0 sees the pre-update value
  always_ff @(posedge Clk) begin
    if (rst)                   acc_q <= '0;
    else if (acc_clr)          acc_q <= '0;
    else if (valido && readyi) acc_q <= data_out;
  end
endmodule

// File: tb/tb_alu_chain_pipe.sv
// Bench for alu_chain_pipe (WIDTH=8, STAGES=2): vector table, directed corner
// sequences and random traffic checked against a sample-level reference model.
module tb_alu_chain_pipe;
  localparam int W = 8, S = 2, OPW = 3;
`ifdef ALU_CHAIN_SAT_EN
  localparam logic [W-1:0] SUB_LO = 8'h00, ADD_HI = 8'hFF, ADD_HI2 = 8'hFF;
`else
  localparam logic [W-1:0] SUB_LO = 8'hFE, ADD_HI = 8'h01, ADD_HI2 = 8'h00;
`endif

  logic Clk = 1'b0;
  logic rst, validi, ready_o, valido, readyi, acc_clr, cfg_we, cfg_busy;
  logic [W-1:0] data_in, data_out, acc_out;
  logic [S*OPW-1:0] op_cfg;

  alu_chain_pipe #(.WIDTH(W), .STAGES(S), .OPW(OPW)) dut (
    .Clk(Clk), .rst(rst), .validi(validi), .ready_o(ready_o), .data_in(data_in),
    .valido(valido), .readyi(readyi), .data_out(data_out), .acc_out(acc_out),
    .acc_clr(acc_clr), .cfg_we(cfg_we), .op_cfg(op_cfg), .cfg_busy(cfg_busy)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_fail = 0;
  logic [W-1:0] m_acc;
  logic [2:0]   m_ops [S];
  logic [W-1:0] m_q [$];

  typedef struct {
    logic [2:0] op0;
    logic [2:0] op1;
    logic [7:0] pre;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] alu(input logic [2:0] op, input int a, input int b);
    int r;
    case (op)
      3'd0: begin
        r = a + b;
`ifdef ALU_CHAIN_SAT_EN
        if (r > 255) r = 255;
`endif
      end
      3'd1: begin
        r = a - b;
`ifdef ALU_CHAIN_SAT_EN
        if (r < 0) r = 0;
`endif
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << (b % 8);
      3'd6: r = a;
      default: r = b;
    endcase
    return W'(r);
  endfunction

  function automatic logic [W-1:0] chain(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = alu(m_ops[0], int'(m_acc), int'(x));
    for (int k = 1; k < S; k++) r = alu(m_ops[k], int'(r), int'(x));
    return r;
  endfunction

  task automatic m_reset();
    m_acc = '0;
    m_q.delete();
    for (int k = 0; k < S; k++) m_ops[k] = 3'd0;
    m_ops[0] = 3'd6;
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance model with the edge.
  task automatic step(input logic vi, input logic [W-1:0] d, input logic ri, input logic clr,
                      input logic we, input logic [S*OPW-1:0] ops,
                      output logic hs, output logic [W-1:0] dout);
    logic [W-1:0] nacc;
    logic acc_in, load;
    validi = vi; data_in = d; readyi = ri; acc_clr = clr; cfg_we = we; op_cfg = ops;
    #1;
    hs = valido && readyi;
    dout = data_out;
    check("ready_o", 8'(ready_o), 8'(!valido || readyi));
    if (valido) begin
      if (m_q.size() == 0) check("spurious_valido", 8'(valido), 8'd0);
      else check("data_out", data_out, m_q[0]);
    end
    acc_in = validi && ready_o;
    load = we && (m_q.size() == 0) && !acc_in;
    nacc = m_acc;
    if (acc_in) m_q.push_back(chain(d));
    if (hs && m_q.size() != 0) nacc = m_q.pop_front();
    if (clr) nacc = '0;
    if (load) for (int k = 0; k < S; k++) m_ops[k] = ops[k*OPW +: OPW];
    @(posedge Clk); #1;
    m_acc = nacc;
    check("acc_out", acc_out, m_acc);
    check("cfg_busy", 8'(cfg_busy), 8'(m_q.size() != 0));
  endtask

  task automatic drain(output logic [W-1:0] got);
    logic hs;
    logic [W-1:0] dout;
    bit seen = 0;
    got = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, hs, dout);
      if (hs) begin seen = 1; got = dout; end
    end
    if (!seen) check("drain_timeout", 8'd0, 8'd1);
  endtask

  task automatic send_wait(input logic [W-1:0] d, output logic [W-1:0] got);
    logic hs;
    logic [W-1:0] dout;
    step(1'b1, d, 1'b1, 1'b0, 1'b0, '0, hs, dout);
    drain(got);
  endtask

  task automatic cfg(input logic [S*OPW-1:0] ops);
    logic hs;
    logic [W-1:0] dout;
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, ops, hs, dout);
  endtask

  task automatic clr_acc();
    logic hs;
    logic [W-1:0] dout;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, hs, dout);
  endtask

  task automatic do_reset();
    rst = 1'b1; validi = 0; readyi = 0; acc_clr = 0; cfg_we = 0; data_in = '0; op_cfg = '0;
    @(posedge Clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    logic hs;
    logic [W-1:0] dout, got;
    logic [W-1:0] outs [$];

    vt[0]  = '{3'd0, 3'd6, 8'h10, 8'h22, 8'h32};
    vt[1]  = '{3'd1, 3'd6, 8'h05, 8'h03, 8'h02};
    vt[2]  = '{3'd6, 3'd1, 8'h03, 8'h05, SUB_LO};
    vt[3]  = '{3'd7, 3'd1, 8'h00, 8'h03, 8'h00};
    vt[4]  = '{3'd6, 3'd0, 8'hFF, 8'h02, ADD_HI};
    vt[5]  = '{3'd2, 3'd6, 8'hF0, 8'h3C, 8'h30};
    vt[6]  = '{3'd3, 3'd6, 8'hF0, 8'h0C, 8'hFC};
    vt[7]  = '{3'd4, 3'd6, 8'hFF, 8'h0F, 8'hF0};
    vt[8]  = '{3'd5, 3'd0, 8'h03, 8'h0A, 8'h16};
    vt[9]  = '{3'd4, 3'd5, 8'h81, 8'h05, 8'h80};
    vt[10] = '{3'd0, 3'd0, 8'h80, 8'h40, ADD_HI2};
    vt[11] = '{3'd7, 3'd7, 8'h55, 8'hAA, 8'hAA};

    // reset state and default opcodes, with latency
    do_reset();
    check("rst_valido", 8'(valido), 8'd0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_acc_out", acc_out, 8'h00);
    check("rst_ready_o", 8'(ready_o), 8'd1);
    check("rst_cfg_busy", 8'(cfg_busy), 8'd0);
    step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, '0, hs, dout);
    check("lat_early_valido", 8'(valido), 8'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, hs, dout);
    check("lat_valido", 8'(valido), 8'd1);
    check("lat_data_out", data_out, 8'h05);
    drain(got);
    check("default_acc", acc_out, 8'h05);
    send_wait(8'h03, got);
    check("default_second", got, 8'h08);

    // back-to-back, no accumulator forwarding
    clr_acc();
    cfg({3'd6, 3'd0});
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0, 1'b0, '0, hs, dout);
      if (hs) outs.push_back(dout);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, hs, dout);
      if (hs) outs.push_back(dout);
    end
    check("b2b_count", 8'(outs.size()), 8'd3);
    for (int i = 0; i < outs.size() && i < 3; i++) check("b2b_out", outs[i], W'(i + 1));
    check("b2b_acc", acc_out, 8'h03);
    send_wait(8'h01, got); check("gap_out0", got, 8'h04);
    send_wait(8'h02, got); check("gap_out1", got, 8'h06);
    send_wait(8'h03, got); check("gap_out2", got, 8'h09);

    // backpressure
    clr_acc();
    cfg({3'd0, 3'd6});
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, '0, hs, dout);
    step(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, '0, hs, dout);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, '0, hs, dout);
      check("bp_ready_o", 8'(ready_o), 8'd0);
      check("bp_hold", data_out, 8'h0A);
    end
    outs.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, hs, dout);
      if (hs) outs.push_back(dout);
    end
    check("bp_count", 8'(outs.size()), 8'd2);
    if (outs.size() == 2) begin
      check("bp_first", outs[0], 8'h0A);
      check("bp_second", outs[1], 8'h0B);
    end

    // opcode vector table
    for (int i = 0; i < 12; i++) begin
      cfg({3'd6, 3'd7});
      send_wait(vt[i].pre, got);
      check("vec_preload", acc_out, vt[i].pre);
      cfg({vt[i].op1, vt[i].op0});
      send_wait(vt[i].din, got);
      check($sformatf("vec%0d", i), got, vt[i].exp);
    end

    // config while busy is dropped; config while idle applies to the next sample
    clr_acc();
    cfg({3'd0, 3'd6});
    step(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, '0, hs, dout);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, {3'd5, 3'd7}, hs, dout);
    drain(got);
    check("cfg_busy_ignored", got, 8'h07);
    cfg({3'd5, 3'd7});
    send_wait(8'h01, got);
    check("cfg_idle_applied", got, 8'h02);

    // random traffic
    clr_acc();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
           (S*OPW)'($urandom), hs, dout);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, hs, dout);
    check("rand_drained", 8'(m_q.size()), 8'd0);

    // reset mid-stream with a stall
    cfg({3'd4, 3'd1});
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, '0, hs, dout);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, '0, hs, dout);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, '0, hs, dout);
    rst = 1'b1; validi = 1'b1; readyi = 1'b1; acc_clr = 1'b0; cfg_we = 1'b1; op_cfg = {3'd5, 3'd5};
    @(posedge Clk); #1;
    rst = 1'b0; validi = 1'b0; readyi = 1'b0; cfg_we = 1'b0;
    #1;
    m_reset();
    check("mid_rst_valido", 8'(valido), 8'd0);
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_acc_out", acc_out, 8'h00);
    check("mid_rst_busy", 8'(cfg_busy), 8'd0);
    check("mid_rst_ready_o", 8'(ready_o), 8'd1);
    send_wait(8'h05, got); check("mid_rst_default0", got, 8'h05);
    send_wait(8'h03, got); check("mid_rst_default1", got, 8'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
